// File: rtl/gate_delay_bank.sv
// gate_delay_bank: multi-channel clocked delay line with programmable
// rise/fall delays, inertial or transport behaviour, busy/reject status.
module gate_delay_bank #(
    parameter int CH = 4,
    parameter int DW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    din,
    input  logic [CH*DW-1:0] rise_dly,
    input  logic [CH*DW-1:0] fall_dly,
    input  logic [CH-1:0]    mode,
    output logic [CH-1:0]    dout,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    rej
);

    localparam int HD = (1 << DW) - 1;
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW:0] INC1 = (DW+1)'(1);
    localparam logic [DW:0] CMAX = {1'b0, {DW{1'b1}}};

    for (genvar g = 0; g < CH; g++) begin : g_ch

        logic [DW-1:0] rd_raw;
        logic [DW-1:0] fd_raw;
        logic [DW-1:0] rd_eff;
        logic [DW-1:0] fd_eff;
        logic [DW-1:0] d_tgt;
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_n;
        logic [DW:0]   inc;
        logic [HD-1:0] hist_q;
        logic [HD:0]   tap;
        logic          dout_q;
        logic          dout_n;
        logic          rej_q;
        logic          rej_n;
        logic          mode_q;
        logic          match;
        logic          pend;
        logic          ev_sw;
        logic          ev_tr;
        logic          ev_rej;
        logic          ev_idle;
        logic          ev_start;
        logic          ev_adv;

        // A programmed delay of zero behaves exactly like one cycle.
        assign rd_raw = rise_dly[g*DW +: DW];
        assign fd_raw = fall_dly[g*DW +: DW];
        assign rd_eff = (rd_raw == '0) ? ONE : rd_raw;
        assign fd_eff = (fd_raw == '0) ? ONE : fd_raw;

        // Inertial delay is chosen by the value being moved towards.
        assign d_tgt = din[g] ? rd_eff : fd_eff;

        // tap[k] is din as seen k edges ago; tap[0] is the live input.
        assign tap = {hist_q, din[g]};

        assign inc   = {1'b0, cnt_q} + INC1;
        assign match = (din[g] == dout_q);
        assign pend  = (cnt_q != '0);

        // Classify this edge into exactly one channel event.
        always_comb begin
            ev_sw    = (mode[g] != mode_q);
            ev_tr    = !ev_sw && mode[g];
            ev_rej   = !ev_sw && !mode[g] && match && pend;
            ev_idle  = !ev_sw && !mode[g] && match && !pend;
            ev_start = !ev_sw && !mode[g] && !match && !pend;
            ev_adv   = !ev_sw && !mode[g] && !match && pend;
        end

        // Next-state logic for counter, output bit and reject strobe.
        always_comb begin
            cnt_n  = cnt_q;
            dout_n = dout_q;
            rej_n  = 1'b0;
            unique case (1'b1)
                ev_sw: begin
                    cnt_n = '0;
                    if (mode[g]) begin
                        dout_n = tap[rd_eff - ONE];
                    end
                end
                ev_tr: begin
                    cnt_n  = '0;
                    dout_n = tap[rd_eff - ONE];
                end
                ev_rej: begin
                    cnt_n = '0;
                    rej_n = 1'b1;
                end
                ev_idle: begin
                    cnt_n = '0;
                end
                ev_start: begin
                    if (d_tgt == ONE) begin
                        dout_n = din[g];
                    end else begin
                        cnt_n = ONE;
                    end
                end
                ev_adv: begin
                    if (inc >= {1'b0, d_tgt}) begin
                        dout_n = din[g];
                        cnt_n  = '0;
                    end else if (inc > CMAX) begin
                        cnt_n = CMAX[DW-1:0];
                    end else begin
                        cnt_n = inc[DW-1:0];
                    end
                end
                default: begin
                    cnt_n = cnt_q;
                end
            endcase
        end

        // Channel state; history shifts every edge in either mode.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                hist_q <= '0;
                dout_q <= 1'b0;
                rej_q  <= 1'b0;
                mode_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_n;
                hist_q <= tap[HD-1:0];
                dout_q <= dout_n;
                rej_q  <= rej_n;
                mode_q <= mode[g];
            end
        end

        // Status is derived from registered state only.
        assign dout[g] = dout_q;
        assign rej[g]  = rej_q;
        assign busy[g] = pend && !mode_q;

    end

endmodule

// File: tb/tb_gate_delay_bank.sv
// tb_gate_delay_bank: directed and random stimulus checked every cycle
// against a run-length / sample-history model of the delay bank.
module tb_gate_delay_bank;

    localparam int CH = 4;
    localparam int DW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    din = '0;
    logic [CH-1:0]    mode = '0;
    logic [CH*DW-1:0] rise_dly = '0;
    logic [CH*DW-1:0] fall_dly = '0;
    logic [CH-1:0]    dout;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    rej;

    int n_chk = 0;
    int n_fail = 0;

    logic [CH-1:0] m_dout;
    logic [CH-1:0] m_rej;
    logic [CH-1:0] m_mprev;
    int            m_run[CH];
    logic [15:0]   m_hist[CH];

    always #5 clk = ~clk;

    gate_delay_bank #(.CH(CH), .DW(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .rise_dly(rise_dly),
        .fall_dly(fall_dly),
        .mode(mode),
        .dout(dout),
        .busy(busy),
        .rej(rej)
    );

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic int eff(input logic [DW-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    function automatic void model_reset();
        m_dout  = '0;
        m_rej   = '0;
        m_mprev = '0;
        for (int i = 0; i < CH; i++) begin
            m_run[i]  = 0;
            m_hist[i] = '0;
        end
    endfunction

    // m_run = consecutive edges din has differed from dout;
    // m_hist[i][k] = din sampled k edges ago (k=0 is this edge).
    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            logic d;
            int rd;
            int fd;
            int dd;
            d  = din[i];
            rd = eff(rise_dly[i*DW +: DW]);
            fd = eff(fall_dly[i*DW +: DW]);
            m_hist[i] = {m_hist[i][14:0], d};
            m_rej[i] = 1'b0;
            if (mode[i] || (mode[i] != m_mprev[i])) begin
                m_run[i] = 0;
                if (mode[i]) m_dout[i] = m_hist[i][rd-1];
            end else if (d == m_dout[i]) begin
                if (m_run[i] > 0) m_rej[i] = 1'b1;
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                dd = d ? rd : fd;
                if (m_run[i] >= dd) begin
                    m_dout[i] = d;
                    m_run[i] = 0;
                end
            end
            m_mprev[i] = mode[i];
        end
    endfunction

    always @(negedge rst_n) model_reset();

    // Advance the model on each edge and compare just after it.
    always @(posedge clk) begin
        logic [CH-1:0] eb;
        if (!rst_n) model_reset();
        else model_step();
        #1;
        for (int i = 0; i < CH; i++) eb[i] = (m_run[i] > 0);
        chk("model_dout", int'(dout), int'(m_dout));
        chk("model_busy", int'(busy), int'(eb));
        chk("model_rej", int'(rej), int'(m_rej));
    end

    task automatic set_d(input int ch, input int r, input int f);
        rise_dly[ch*DW +: DW] = DW'(r);
        fall_dly[ch*DW +: DW] = DW'(f);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dout(input int ch, input logic tgt,
                             input int maxe, output int n);
        n = -1;
        for (int k = 1; k <= maxe; k++) begin
            @(negedge clk);
            if (dout[ch] === tgt) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse(input int ch, input int width, input int total,
                         output int fh, output int hi, output int nb,
                         output int nr, output int fr);
        fh = -1; hi = 0; nb = 0; nr = 0; fr = -1;
        din[ch] = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (dout[ch]) begin
                hi++;
                if (fh < 0) fh = k;
            end
            if (busy[ch]) nb++;
            if (rej[ch]) begin
                nr++;
                if (fr < 0) fr = k;
            end
            if (k == width) din[ch] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fh, hi, nb, nr, fr;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset behaviour
        din = '1;
        for (int i = 0; i < CH; i++) set_d(i, 8, 8);
        wait_dout(0, 1'b1, 20, n);
        chk("rst_first_lat", n, 8);
        tick(2);
        chk("rst_pre_dout", int'(dout), 15);
        din = '0;
        tick(2);
        chk("rst_pre_busy", int'(busy), 15);
        rst_n = 1'b0;
        #1;
        chk("rst_async_dout", int'(dout), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_rej", int'(rej), 0);
        din = '1;
        tick(2);
        rst_n = 1'b1;
        wait_dout(0, 1'b1, 20, n);
        chk("rst_release_lat", n, 8);
        din = '0;
        tick(12);

        // inertial rise/fall on ch0
        set_d(0, 7, 3);
        pulse(0, 20, 20, fh, hi, nb, nr, fr);
        chk("ch0_rise_edge", fh, 7);
        chk("ch0_busy_cycles", nb, 6);
        chk("ch0_rej_count", nr, 0);
        wait_dout(0, 1'b0, 10, n);
        chk("ch0_fall_lat", n, 3);

        // glitch rejection on ch1
        set_d(1, 5, 5);
        pulse(1, 3, 10, fh, hi, nb, nr, fr);
        chk("ch1_glitch_hi", hi, 0);
        chk("ch1_glitch_busy", nb, 3);
        chk("ch1_glitch_rejn", nr, 1);
        chk("ch1_glitch_rej_edge", fr, 4);
        pulse(1, 5, 14, fh, hi, nb, nr, fr);
        chk("ch1_pass_edge", fh, 5);
        chk("ch1_pass_width", hi, 5);
        chk("ch1_pass_busy", nb, 8);
        chk("ch1_pass_rej", nr, 0);

        // transport on ch2
        mode[2] = 1'b1;
        set_d(2, 5, 9);
        tick(20);
        pulse(2, 1, 12, fh, hi, nb, nr, fr);
        chk("ch2_tr1_edge", fh, 5);
        chk("ch2_tr1_width", hi, 1);
        chk("ch2_tr1_busy", nb, 0);
        chk("ch2_tr1_rej", nr, 0);
        pulse(2, 3, 12, fh, hi, nb, nr, fr);
        chk("ch2_tr3_edge", fh, 5);
        chk("ch2_tr3_width", hi, 3);
        set_d(2, 0, 0);
        tick(16);
        pulse(2, 2, 6, fh, hi, nb, nr, fr);
        chk("ch2_tr_d0_edge", fh, 1);
        chk("ch2_tr_d0_width", hi, 2);

        // boundary delays on ch3
        set_d(3, 0, 1);
        din[3] = 1'b1;
        wait_dout(3, 1'b1, 5, n);
        chk("ch3_d0_lat", n, 1);
        din[3] = 1'b0;
        wait_dout(3, 1'b0, 5, n);
        chk("ch3_d1_lat", n, 1);
        set_d(3, 15, 1);
        din[3] = 1'b1;
        wait_dout(3, 1'b1, 20, n);
        chk("ch3_d15_lat", n, 15);
        din[3] = 1'b0;
        wait_dout(3, 1'b0, 5, n);
        chk("ch3_d15_back", n, 1);

        // lowering the delay mid-pend commits on the next edge
        set_d(3, 10, 1);
        din[3] = 1'b1;
        tick(4);
        chk("ch3_lower_busy", int'(busy[3]), 1);
        chk("ch3_lower_pre", int'(dout[3]), 0);
        set_d(3, 3, 1);
        tick(1);
        chk("ch3_lower_commit", int'(dout[3]), 1);
        chk("ch3_lower_idle", int'(busy[3]), 0);
        din[3] = 1'b0;
        tick(3);

        // mode flip in the middle of a pending rise
        set_d(0, 10, 10);
        din[0] = 1'b1;
        tick(3);
        chk("flip_pre_busy", int'(busy[0]), 1);
        mode[0] = 1'b1;
        tick(1);
        chk("flip_busy", int'(busy[0]), 0);
        chk("flip_rej", int'(rej[0]), 0);
        chk("flip_dout", int'(dout[0]), 0);
        mode[0] = 1'b0;
        tick(1);
        chk("flip_back_busy", int'(busy[0]), 0);
        tick(1);
        chk("flip_restart", int'(busy[0]), 1);
        din[0] = 1'b0;
        tick(1);
        chk("flip_then_rej", int'(rej[0]), 1);
        tick(2);

        // concurrent random traffic in mixed modes
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom % 4 == 0) din[i] = ~din[i];
                if ($urandom % 16 == 0)
                    set_d(i, $urandom % 16, $urandom % 16);
                if ($urandom % 64 == 0) mode[i] = ~mode[i];
            end
            if (c == 300) begin
                rst_n = 1'b0;
                #2;
                chk("rand_rst_dout", int'(dout), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
